// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Contents:
//   arb_state_t       : arbiter FSM state (core priority / forced DMA burst)
//   CNT_W             : width of the wait and burst counters
//   WAIT_MAX_DEF      : default conflict cycles before a forced DMA burst
//   BURST_MAX_DEF     : default maximum DMA grants per forced burst
package mem_arb_pkg;

  localparam int CNT_W         = 8;
  localparam int WAIT_MAX_DEF  = 8;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic {
    CORE_PRI  = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core/DMA arbiter for a single shared memory port
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   core_req/we/adr/wd -> core_stall/rd : multicycle core access, stalled when denied
//   dma_req/we/adr/wd  -> dma_gnt/rd/rvalid : DMA access, read data returned one cycle later
//   mem_we/adr/wd, mem_rd               : shared memory port (combinational read)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_MAX  = WAIT_MAX_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_wd,
  output logic        core_stall,
  output logic [31:0] core_rd,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic        dma_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] burst_cnt;

  logic core_first;
  logic core_granted;
  logic dma_granted;

  // During reset the grant logic behaves as if already back in CORE_PRI,
  // so a burst in progress stops taking priority immediately.
  always_comb begin
    core_first   = reset | (state == CORE_PRI);
    core_granted = 1'b0;
    dma_granted  = 1'b0;
    if (core_first) begin
      core_granted = core_req;
      dma_granted  = ~core_req & dma_req;
    end else begin
      dma_granted  = dma_req;
      core_granted = ~dma_req & core_req;
    end
  end

  assign core_stall = core_req & ~core_granted;
  assign dma_gnt    = dma_granted;
  assign core_rd    = mem_rd;

  // Idle port still presents the core address so the core can see read data
  // combinationally; only the write enable is forced off.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = core_adr;
    mem_wd  = core_wd;
    if (dma_granted) begin
      mem_we  = dma_we;
      mem_adr = dma_adr;
      mem_wd  = dma_wd;
    end else if (core_granted) begin
      mem_we  = core_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CORE_PRI;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      dma_rvalid <= 1'b0;
      dma_rd     <= '0;
    end else begin
      dma_rvalid <= dma_granted & ~dma_we;
      if (dma_granted & ~dma_we) begin
        dma_rd <= mem_rd;
      end

      case (state)
        CORE_PRI: begin
          if (core_req & dma_req) begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt  <= '0;
              burst_cnt <= '0;
              state     <= DMA_BURST;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            // no DMA request, or DMA got the port: starvation streak is over
            wait_cnt <= '0;
          end
        end
        DMA_BURST: begin
          if (dma_req) begin
            if (burst_cnt == BURST_LAST) begin
              burst_cnt <= '0;
              state     <= CORE_PRI;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            burst_cnt <= '0;
            state     <= CORE_PRI;
          end
        end
        default: begin
          state     <= CORE_PRI;
          wait_cnt  <= '0;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8: consecutive conflict cycles before DMA gets a forced burst (range 2..255).
REQ-002 SHALL have parameter BURST_MAX, default 4: maximum consecutive DMA grants per forced burst (range 1..255).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have core_req in 1, core_we in 1, core_adr in 32, core_wd in 32: the multicycle core's access request for the current cycle.
REQ-006 SHALL have core_stall out 1 and core_rd out 32: core access denied this cycle, and read data for the core.
REQ-007 SHALL have dma_req in 1, dma_we in 1, dma_adr in 32, dma_wd in 32: the DMA/loader access request.
REQ-008 SHALL have dma_gnt out 1, dma_rd out 32, dma_rvalid out 1: DMA granted this cycle, registered read data, and its valid strobe.
REQ-009 SHALL have mem_we out 1, mem_adr out 32, mem_wd out 32, mem_rd in 32: the single shared memory port (combinational read, write on clk edge).

Function
REQ-010 SHALL hold FSM state in {CORE_PRI, DMA_BURST}, plus wait_cnt and burst_cnt, each 8 bits.
REQ-011 SHALL compute grants combinationally from the current state and requests, so a granted access completes in the same cycle.
REQ-012 In CORE_PRI, SHALL grant core if core_req; else grant DMA if dma_req; else grant nobody.
REQ-013 In DMA_BURST, SHALL grant DMA if dma_req; else grant core if core_req.
REQ-014 SHALL drive core_stall = core_req & ~core_granted, and dma_gnt = DMA granted.
REQ-015 SHALL drive mem_adr, mem_wd and mem_we from the granted requester; mem_we SHALL be 1 only as the granted requester's we.
REQ-016 With no grant, SHALL drive mem_we=0, mem_adr=core_adr and mem_wd=core_wd.
REQ-017 SHALL drive core_rd = mem_rd combinationally at all times.
REQ-018 On a granted DMA read, SHALL register mem_rd into dma_rd and pulse dma_rvalid=1 on the following cycle.
REQ-019 SHALL hold dma_rvalid=0 otherwise; dma_rd SHALL hold its last value.
REQ-020 In CORE_PRI, when core_req & dma_req, SHALL increment wait_cnt.
REQ-021 In CORE_PRI, when that conflict occurs with wait_cnt==WAIT_MAX-1, SHALL instead clear wait_cnt, clear burst_cnt and enter DMA_BURST.
REQ-022 In CORE_PRI, SHALL clear wait_cnt when dma_req=0 or when DMA is granted.
REQ-023 In DMA_BURST, each DMA grant SHALL increment burst_cnt.
REQ-024 In DMA_BURST, a DMA grant with burst_cnt==BURST_MAX-1 SHALL return the FSM to CORE_PRI with burst_cnt cleared.
REQ-025 In DMA_BURST, dma_req=0 SHALL return the FSM to CORE_PRI the next cycle, with burst_cnt cleared; a core_req in that cycle is granted per REQ-013.
REQ-026 Counters SHALL never exceed their limit; no wrap-around is reachable.
REQ-027 Simultaneous core write and DMA write to the same address SHALL resolve to the granted requester only; no merge occurs.

Reset
REQ-028 reset=1 at a clock edge SHALL set state=CORE_PRI, wait_cnt=0, burst_cnt=0, dma_rvalid=0 and dma_rd=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no dma_rvalid is issued for a read granted in the reset cycle.
REQ-030 While reset=1, grants SHALL follow CORE_PRI rules; the memory write is still suppressed only by the requester.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum type, the WAIT_MAX/BURST_MAX default constants and the counter width constant (8).
REQ-032 SHALL be a single module with no sub-module; counters and FSM are inline.

Verification
REQ-033 Core only, core_req=1, core_adr=0x40, mem_rd=0x00A00093 -> core_stall=0, mem_adr=0x40, core_rd=0x00A00093, dma_gnt=0.
REQ-034 DMA only, write dma_adr=0x100 dma_wd=0xDEADBEEF -> dma_gnt=1, mem_we=1, mem_adr=0x100, mem_wd=0xDEADBEEF same cycle.
REQ-035 Both requesting continuously, defaults -> core granted cycles 0-7; DMA granted cycles 8-11 with core_stall=1; core granted again at cycle 12; pattern repeats.
REQ-036 DMA read at 0x200, mem_rd=0x12345678 -> dma_rvalid=1 and dma_rd=0x12345678 exactly one cycle later, for one cycle.
REQ-037 Forced burst, dma_req drops after 2 DMA grants -> core granted in that cycle; state=CORE_PRI the next cycle with counters 0.
REQ-038 reset=1 in the 2nd DMA_BURST cycle -> next cycle state=CORE_PRI, dma_rvalid=0, core granted if requesting.
